// File: rtl/i2c_slave_receiver.sv
// -----------------------------------------------------------------------------
// i2c_slave_receiver
//
// Slave-side receive sequencer. Sits downstream of the slave byte reader,
// detects START/STOP on the bus, gates the byte reader, matches the 7-bit
// address, drives ACK/NACK on SDA and hands every accepted write-data byte
// to the local side through a single-entry valid/ready holding register.
// Read transfers (R/W=1) are NACKed; they belong to the transmit path.
//
// Parameters:
//   SLAVE_ADDR        7-bit address this slave responds to
//
// Ports:
//   clk               system clock, all logic on rising edge
//   rst_n             asynchronous active-low reset
//   scl_i, sda_i      bus levels, already synchronous to clk
//   sda_o             SDA drive (0 = pull low, 1 = release)
//   byte_read_en      enable to the byte reader
//   byte_read_o       byte from the byte reader, MSB first
//   byte_read_finish  one-cycle pulse, 8 bits received
//   byte_read_err     bit-level error from the byte reader
//   rx_data/rx_valid  held data byte and its valid flag
//   rx_ready          local side accepts rx_data
//   rx_start, rx_stop one-cycle pulses for START/repeated START and STOP
//   rx_overflow       one-cycle pulse, data byte NACKed because holding reg full
//   rx_err            one-cycle pulse, reader error during an active byte read
//   busy              high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module i2c_slave_receiver #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       byte_read_en,
  input  logic [7:0] byte_read_o,
  input  logic       byte_read_finish,
  input  logic       byte_read_err,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_start,
  output logic       rx_stop,
  output logic       rx_overflow,
  output logic       rx_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_FALL = 3'd1,
    ST_ADDR      = 3'd2,
    ST_DATA      = 3'd3,
    ST_ACK_WAIT  = 3'd4,
    ST_ACK_HOLD  = 3'd5,
    ST_IGNORE    = 3'd6
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  logic scl_last_r;
  logic sda_last_r;
  logic ack_r;
  logic ack_nxt_s;

  logic start_s;
  logic stop_s;
  logic scl_fall_s;
  logic addr_match_s;
  logic load_s;
  logic overflow_s;
  logic err_s;
  logic rx_valid_nxt_s;

  // Bus conditions: SDA edges while SCL stays high are START/STOP.
  assign start_s      = scl_i & scl_last_r & sda_last_r & ~sda_i;
  assign stop_s       = scl_i & scl_last_r & ~sda_last_r & sda_i;
  assign scl_fall_s   = scl_last_r & ~scl_i;
  // Only a write (R/W=0) to our address is acknowledged here.
  assign addr_match_s = (byte_read_o[7:1] == SLAVE_ADDR) & ~byte_read_o[0];

  // Previous bus levels for edge detection; idle bus is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_last_r <= 1'b1;
      sda_last_r <= 1'b1;
    end else begin
      scl_last_r <= scl_i;
      sda_last_r <= sda_i;
    end
  end

  // Next-state logic; bus conditions override byte events (STOP > START > err > finish).
  always_comb begin
    state_nxt_s = state_r;
    ack_nxt_s   = ack_r;
    load_s      = 1'b0;
    overflow_s  = 1'b0;
    err_s       = 1'b0;
    if (stop_s) begin
      state_nxt_s = ST_IDLE;
    end else if (start_s) begin
      state_nxt_s = ST_WAIT_FALL;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_IDLE;
        end
        ST_WAIT_FALL: begin
          // The reader must only be enabled once SCL is low after START.
          if (scl_fall_s) begin
            state_nxt_s = ST_ADDR;
          end else begin
            state_nxt_s = ST_WAIT_FALL;
          end
        end
        ST_ADDR: begin
          if (byte_read_err) begin
            err_s       = 1'b1;
            state_nxt_s = ST_IGNORE;
          end else if (byte_read_finish) begin
            if (addr_match_s) begin
              ack_nxt_s   = 1'b1;
              state_nxt_s = ST_ACK_WAIT;
            end else begin
              state_nxt_s = ST_IGNORE;
            end
          end else begin
            state_nxt_s = ST_ADDR;
          end
        end
        ST_DATA: begin
          if (byte_read_err) begin
            err_s       = 1'b1;
            state_nxt_s = ST_IGNORE;
          end else if (byte_read_finish) begin
            state_nxt_s = ST_ACK_WAIT;
            // A byte consumed in this same cycle frees the slot for the new one.
            if (!rx_valid || rx_ready) begin
              load_s    = 1'b1;
              ack_nxt_s = 1'b1;
            end else begin
              ack_nxt_s  = 1'b0;
              overflow_s = 1'b1;
            end
          end else begin
            state_nxt_s = ST_DATA;
          end
        end
        ST_ACK_WAIT: begin
          // Falling SCL ends the 8th bit; the ACK slot starts now.
          if (scl_fall_s) begin
            if (ack_r) begin
              state_nxt_s = ST_ACK_HOLD;
            end else begin
              state_nxt_s = ST_IGNORE;
            end
          end else begin
            state_nxt_s = ST_ACK_WAIT;
          end
        end
        ST_ACK_HOLD: begin
          // Falling SCL after the 9th high ends the ACK slot.
          if (scl_fall_s) begin
            state_nxt_s = ST_DATA;
          end else begin
            state_nxt_s = ST_ACK_HOLD;
          end
        end
        ST_IGNORE: begin
          state_nxt_s = ST_IGNORE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Holding-register valid flag: a load wins over a simultaneous consume.
  always_comb begin
    rx_valid_nxt_s = rx_valid;
    if (load_s) begin
      rx_valid_nxt_s = 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_valid_nxt_s = 1'b0;
    end else begin
      rx_valid_nxt_s = rx_valid;
    end
  end

  // State, ACK decision and bus-facing outputs, all derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      ack_r        <= 1'b0;
      sda_o        <= 1'b1;
      byte_read_en <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      ack_r        <= ack_nxt_s;
      // SDA is only ever pulled low while holding an ACK.
      sda_o        <= (state_nxt_s != ST_ACK_HOLD);
      // Leaving ADDR/DATA for any reason drops the enable, which also clears
      // the reader's bit counter on a repeated START or error.
      byte_read_en <= (state_nxt_s == ST_ADDR) || (state_nxt_s == ST_DATA);
      busy         <= (state_nxt_s != ST_IDLE);
    end
  end

  // Event pulses, one cycle each, in the cycle after the event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_start    <= 1'b0;
      rx_stop     <= 1'b0;
      rx_overflow <= 1'b0;
      rx_err      <= 1'b0;
    end else begin
      rx_start    <= start_s;
      rx_stop     <= stop_s;
      rx_overflow <= overflow_s;
      rx_err      <= err_s;
    end
  end

  // Local-side holding register; untouched by START, STOP or errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
    end else begin
      if (load_s) begin
        rx_data <= byte_read_o;
      end else begin
        rx_data <= rx_data;
      end
      rx_valid <= rx_valid_nxt_s;
    end
  end

endmodule

// File: tb/tb_i2c_slave_receiver.sv
// -----------------------------------------------------------------------------
// tb_i2c_slave_receiver
//
// Drives an I2C master and a behavioural byte reader into i2c_slave_receiver.
// Accepted data bytes are pushed to a scoreboard queue when sent and popped
// when the DUT hands them to the local side.
// -----------------------------------------------------------------------------
module tb_i2c_slave_receiver;

  localparam int H = 6;  // clocks per SCL phase

  logic       clk;
  logic       rst_n;
  logic       m_scl;
  logic       m_sda;
  wire        sda_bus;
  logic       sda_o;
  logic       byte_read_en;
  logic [7:0] byte_read_o;
  logic       byte_read_finish;
  logic       byte_read_err;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_start;
  logic       rx_stop;
  logic       rx_overflow;
  logic       rx_err;
  logic       busy;

  assign sda_bus = m_sda & sda_o;

  i2c_slave_receiver dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .scl_i            (m_scl),
    .sda_i            (sda_bus),
    .sda_o            (sda_o),
    .byte_read_en     (byte_read_en),
    .byte_read_o      (byte_read_o),
    .byte_read_finish (byte_read_finish),
    .byte_read_err    (byte_read_err),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .rx_start         (rx_start),
    .rx_stop          (rx_stop),
    .rx_overflow      (rx_overflow),
    .rx_err           (rx_err),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total;
  int n_bad;
  int cnt_start, cnt_stop, cnt_ovf, cnt_err, cnt_en, cnt_valid;
  logic [7:0] exp_q[$];
  logic [7:0] rd_sh;
  int         rd_cnt;
  logic       rd_scl_prev;
  logic       en_after_start;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One negedge sample: byte reader model, pulse counters, scoreboard.
  task automatic sample();
    if (!byte_read_en) begin
      rd_cnt           = 0;
      byte_read_finish = 1'b0;
    end else begin
      byte_read_finish = 1'b0;
      if (m_scl && !rd_scl_prev) begin
        rd_sh  = {rd_sh[6:0], sda_bus};
        rd_cnt = rd_cnt + 1;
        if (rd_cnt == 8) begin
          byte_read_o      = rd_sh;
          byte_read_finish = 1'b1;
          rd_cnt           = 0;
        end
      end
    end
    rd_scl_prev = m_scl;
    if (rx_start)     cnt_start++;
    if (rx_stop)      cnt_stop++;
    if (rx_overflow)  cnt_ovf++;
    if (rx_err)       cnt_err++;
    if (byte_read_en) cnt_en++;
    if (rx_valid)     cnt_valid++;
    if (rst_n && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_extra", 32'(rx_data), 32'hFFFF_FFFF);
      end else begin
        check("sb_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
    end
  endtask

  // Advance n clocks: sample at each negedge, return 2 units after posedge.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      sample();
      @(posedge clk);
      #2;
    end
  endtask

  task automatic start_cond();
    m_sda = 1'b1; tick(H);
    m_scl = 1'b1; tick(H);
    m_sda = 1'b0; tick(2);
    en_after_start = byte_read_en;
    tick(H - 2);
    m_scl = 1'b0; tick(H);
  endtask

  task automatic stop_cond();
    m_sda = 1'b0; tick(H);
    m_scl = 1'b1; tick(H);
    m_sda = 1'b1; tick(H);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;    tick(H);
    m_scl = 1'b1; tick(H);
    m_scl = 1'b0; tick(1);
  endtask

  // Eight data bits plus the ACK slot; bad flags any slave drive during data bits.
  task automatic write_byte(input logic [7:0] b, output logic ack, output logic bad);
    bad = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; tick(H);
      m_scl = 1'b1; tick(H / 2);
      if (!sda_o) bad = 1'b1;
      tick(H / 2);
      m_scl = 1'b0; tick(1);
    end
    m_sda = 1'b1; tick(H);
    m_scl = 1'b1; tick(H / 2);
    ack = ~sda_bus;
    tick(H / 2);
    m_scl = 1'b0; tick(3);
  endtask

  initial begin
    logic ack, bad;
    int s_start, s_stop, s_val, s_en, s_ovf, s_err;
    n_total = 0; n_bad = 0;
    cnt_start = 0; cnt_stop = 0; cnt_ovf = 0; cnt_err = 0; cnt_en = 0; cnt_valid = 0;
    rd_sh = 8'h00; rd_cnt = 0; rd_scl_prev = 1'b1; en_after_start = 1'b0;
    rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1;
    byte_read_o = 8'h00; byte_read_finish = 1'b0; byte_read_err = 1'b0;
    rx_ready = 1'b1;
    tick(3);
    check("rst_sda",    32'(sda_o), 32'd1);
    check("rst_en",     32'(byte_read_en), 32'd0);
    check("rst_data",   32'(rx_data), 32'h00);
    check("rst_valid",  32'(rx_valid), 32'd0);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_pulses", 32'({rx_start, rx_stop, rx_overflow, rx_err}), 32'd0);
    rst_n = 1'b1;
    tick(4);

    // T1: write 0x3C to our address
    s_start = cnt_start; s_stop = cnt_stop; s_val = cnt_valid;
    exp_q.push_back(8'h3C);
    start_cond();
    write_byte(8'hA0, ack, bad);
    check("t1_addr_ack", 32'(ack), 32'd1);
    check("t1_addr_drv", 32'(bad), 32'd0);
    check("t1_addr_rel", 32'(sda_o), 32'd1);
    write_byte(8'h3C, ack, bad);
    check("t1_data_ack", 32'(ack), 32'd1);
    check("t1_data_drv", 32'(bad), 32'd0);
    check("t1_data_rel", 32'(sda_o), 32'd1);
    stop_cond(); tick(4);
    check("t1_busy",  32'(busy), 32'd0);
    check("t1_start", 32'(cnt_start - s_start), 32'd1);
    check("t1_stop",  32'(cnt_stop - s_stop), 32'd1);
    check("t1_valid", 32'(cnt_valid > s_val), 32'd1);

    // T2: other address, nothing acknowledged or delivered
    s_val = cnt_valid;
    start_cond();
    write_byte(8'hA2, ack, bad);
    check("t2_addr_nack", 32'(ack), 32'd0);
    write_byte(8'h77, ack, bad);
    check("t2_data_nack", 32'(ack), 32'd0);
    check("t2_drv", 32'(bad), 32'd0);
    stop_cond(); tick(4);
    check("t2_valid", 32'(cnt_valid - s_val), 32'd0);
    check("t2_busy",  32'(busy), 32'd0);

    // T3: read request is NACKed and the reader stays disabled
    start_cond();
    write_byte(8'hA1, ack, bad);
    check("t3_addr_nack", 32'(ack), 32'd0);
    s_en = cnt_en;
    write_byte(8'h55, ack, bad);
    check("t3_data_nack", 32'(ack), 32'd0);
    check("t3_en_off", 32'(cnt_en - s_en), 32'd0);
    stop_cond(); tick(4);
    check("t3_busy", 32'(busy), 32'd0);

    // T4: holding register full -> overflow NACK
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    start_cond();
    write_byte(8'hA0, ack, bad);
    check("t4_addr_ack", 32'(ack), 32'd1);
    write_byte(8'h11, ack, bad);
    check("t4_d1_ack", 32'(ack), 32'd1);
    s_ovf = cnt_ovf;
    write_byte(8'h22, ack, bad);
    check("t4_d2_nack", 32'(ack), 32'd0);
    check("t4_ovf",   32'(cnt_ovf - s_ovf), 32'd1);
    check("t4_data",  32'(rx_data), 32'h11);
    check("t4_valid", 32'(rx_valid), 32'd1);
    s_en = cnt_en;
    write_byte(8'h33, ack, bad);
    check("t4_d3_nack", 32'(ack), 32'd0);
    check("t4_en_off",  32'(cnt_en - s_en), 32'd0);
    stop_cond(); tick(4);
    rx_ready = 1'b1;
    tick(4);
    check("t4_drained", 32'(rx_valid), 32'd0);

    // T5: repeated START in the middle of a data byte
    s_start = cnt_start;
    exp_q.push_back(8'h5A);
    start_cond();
    write_byte(8'hA0, ack, bad);
    check("t5_addr_ack", 32'(ack), 32'd1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    start_cond();
    check("t5_en_low", 32'(en_after_start), 32'd0);
    write_byte(8'hA0, ack, bad);
    check("t5_readdr_ack", 32'(ack), 32'd1);
    write_byte(8'h5A, ack, bad);
    check("t5_data_ack", 32'(ack), 32'd1);
    stop_cond(); tick(4);
    check("t5_start", 32'(cnt_start - s_start), 32'd2);
    check("t5_data",  32'(rx_data), 32'h5A);

    // T6: reader error mid-byte, then reset during an ACK hold
    start_cond();
    write_byte(8'hA0, ack, bad);
    check("t6_addr_ack", 32'(ack), 32'd1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    s_err = cnt_err;
    byte_read_err = 1'b1; tick(1);
    byte_read_err = 1'b0; tick(2);
    check("t6_err", 32'(cnt_err - s_err), 32'd1);
    s_en = cnt_en;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    check("t6_en_off", 32'(cnt_en - s_en), 32'd0);
    check("t6_busy",   32'(busy), 32'd1);
    start_cond();
    for (int i = 7; i >= 0; i--) send_bit((8'hA0 >> i) & 8'h01);
    m_sda = 1'b1; tick(H);
    m_scl = 1'b1; tick(2);
    check("t6_hold", 32'(sda_o), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_sda",   32'(sda_o), 32'd1);
    check("t6_rst_en",    32'(byte_read_en), 32'd0);
    check("t6_rst_data",  32'(rx_data), 32'h00);
    check("t6_rst_valid", 32'(rx_valid), 32'd0);
    check("t6_rst_busy",  32'(busy), 32'd0);
    check("t6_rst_pulse", 32'({rx_start, rx_stop, rx_overflow, rx_err}), 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(4);
    check("t6_idle", 32'(busy), 32'd0);
    check("sb_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
